// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the lower-level port arbiter.
package cache_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // Round-robin successor of ptr among num_req requesters.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr >= num_req - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // cand[k] is the requester k positions after rr_ptr; hit[k] says it is pending.
  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign cand[gi] = (int'(rr_ptr) + gi >= NUM_REQ) ? IDX_W'(int'(rr_ptr) + gi - NUM_REQ)
                                                     : IDX_W'(int'(rr_ptr) + gi);
    assign hit[gi]  = pending[cand[gi]];
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one lower-level memory port between NUM_REQ caches,
// with a watchdog that aborts transactions the lower level never answers.
module l2_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_miss,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_LENGTH-1:0] req_addr,
  output logic [BLOCK_SIZE-1:0]          req_data_out,
  output logic [NUM_REQ-1:0]             req_fetchReceive,
  output logic                           mem_enable,
  output logic                           mem_write,
  output logic [ADDR_LENGTH-1:0]         mem_addr,
  input  logic [BLOCK_SIZE-1:0]          mem_data_in,
  input  logic                           mem_fetchComplete,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t             state_reg, state_next;
  logic [NUM_REQ-1:0]     prev_miss_reg;
  logic [NUM_REQ-1:0]     pending_reg, pending_next, pending_set, pending_clr;
  logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]       grant_reg, grant_next;
  logic [CNT_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic [ADDR_LENGTH-1:0] mem_addr_reg, mem_addr_next;
  logic                   mem_write_reg, mem_write_next;
  logic                   mem_enable_reg, mem_enable_next;
  logic [BLOCK_SIZE-1:0]  data_reg, data_next;
  logic [NUM_REQ-1:0]     fetch_reg, fetch_next;
  logic                   busy_reg, busy_next;
  logic                   timeout_reg, timeout_next;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [ADDR_LENGTH-1:0] addr_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*ADDR_LENGTH +: ADDR_LENGTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .pending     (pending_reg),
    .rr_ptr      (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A miss edge arriving in the same cycle as its own grant-clear must survive.
  assign pending_set  = req_miss & ~prev_miss_reg;
  assign pending_next = (pending_reg & ~pending_clr) | pending_set;

  always_comb begin
    state_next      = state_reg;
    pending_clr     = '0;
    rr_ptr_next     = rr_ptr_reg;
    grant_next      = grant_reg;
    wait_cnt_next   = wait_cnt_reg;
    mem_addr_next   = mem_addr_reg;
    mem_write_next  = mem_write_reg;
    mem_enable_next = 1'b0;
    data_next       = data_reg;
    fetch_next      = '0;
    timeout_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          grant_next      = grant_idx;
          mem_addr_next   = addr_arr[grant_idx];
          mem_write_next  = req_write[grant_idx];
          pending_clr     = NUM_REQ'(1) << grant_idx;
          mem_enable_next = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        if (mem_fetchComplete) begin
          data_next  = mem_data_in;
          fetch_next = NUM_REQ'(1) << grant_reg;
          state_next = RESPOND;
        end else if (wait_cnt_reg == CNT_LAST) begin
          data_next    = '0;
          timeout_next = 1'b1;
          fetch_next   = NUM_REQ'(1) << grant_reg;
          state_next   = RESPOND;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      RESPOND: begin
        rr_ptr_next = IDX_W'(rr_next(32'(grant_reg), NUM_REQ));
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      prev_miss_reg  <= '0;
      pending_reg    <= '0;
      rr_ptr_reg     <= '0;
      grant_reg      <= '0;
      wait_cnt_reg   <= '0;
      mem_addr_reg   <= '0;
      mem_write_reg  <= 1'b0;
      mem_enable_reg <= 1'b0;
      data_reg       <= '0;
      fetch_reg      <= '0;
      busy_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_miss_reg  <= req_miss;
      pending_reg    <= pending_next;
      rr_ptr_reg     <= rr_ptr_next;
      grant_reg      <= grant_next;
      wait_cnt_reg   <= wait_cnt_next;
      mem_addr_reg   <= mem_addr_next;
      mem_write_reg  <= mem_write_next;
      mem_enable_reg <= mem_enable_next;
      data_reg       <= data_next;
      fetch_reg      <= fetch_next;
      busy_reg       <= busy_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign req_data_out     = data_reg;
  assign req_fetchReceive = fetch_reg;
  assign mem_enable       = mem_enable_reg;
  assign mem_write        = mem_write_reg;
  assign mem_addr         = mem_addr_reg;
  assign busy             = busy_reg;
  assign timeout_err      = timeout_reg;

endmodule
